sm2201_rd_mux_ctrl: RTL and testbench
=====================================

// Module: sm2201_rd_mux_ctrl
// PURPOSE
// - Sequences the ISA-side read path of the SM2201 ISA-CAMAC interface: owns the 16-bit read snapshot
//   feeding the two SN74LS257 byte muxes (a = low byte, b = high byte) and drives their select/out_control.
// - Low-byte read fetches a fresh CAMAC word, holding IOCHRDY low until it arrives. High-byte read
//   returns the same snapshot, giving the host a coherent 16-bit word.
// PARAMETERS
// - SYNC_STAGES    2    ior_n synchronizer depth (>=2)
// - TIMEOUT_CYCLES 255  clk cycles to wait for camac_ack before abort (used only with SM2201_RD_TIMEOUT_EN)
// - ABORT_WORD     16'hFFFF  snapshot value loaded on timeout
// PORTS
// - clk          in   1   system clock
// - rst_n        in   1   asynchronous active-low reset
// - ior_n        in   1   ISA IOR strobe, async, active low
// - addr_hit     in   1   board read-port decode; stable while ior_n low
// - addr_a0      in   1   0 = low-byte port, 1 = high-byte port; stable while ior_n low
// - camac_req    out  1   request CAMAC read word
// - camac_ack    in   1   one-cycle pulse; camac_data valid this cycle
// - camac_data   in   16  CAMAC read word
// - iochrdy      out  1   ISA ready; 0 inserts wait states
// - mux_a        out  8   snapshot[7:0] to mux a inputs
// - mux_b        out  8   snapshot[15:8] to mux b inputs
// - mux_sel      out  1   0 = a, 1 = b
// - mux_oe_n     out  1   mux out_control; 1 = outputs Z
// - rd_timeout   out  1   sticky abort flag (only with SM2201_RD_TIMEOUT_EN)
// BEHAVIOUR
// - Reset: camac_req=0, iochrdy=1, mux_oe_n=1, mux_sel=0, snapshot=16'h0000, rd_timeout=0, state IDLE.
// - ior_s = ior_n after SYNC_STAGES flops. rd_lo = !ior_s & addr_hit & !addr_a0. rd_hi = same with addr_a0=1.
// - FSM:
//   IDLE:  rd_lo -> REQ; camac_req=1 and iochrdy=0 registered on the transition cycle.
//          rd_hi -> DRV_HI (snapshot unchanged, stale word allowed).
//   REQ:   camac_ack -> snapshot<=camac_data, camac_req=0, iochrdy=1, next DRV_LO.
//          camac_req held high until ack. ack outside REQ ignored.
//   DRV_LO: mux_sel=0, mux_oe_n=0. ior_s high -> mux_oe_n=1 next edge, next IDLE.
//   DRV_HI: mux_sel=1, mux_oe_n=0. ior_s high -> mux_oe_n=1 next edge, next IDLE.
// - mux_sel is set on the FSM-entry edge, so it is stable >=1 cycle before mux_oe_n falls;
//   mux_oe_n falls the cycle after state entry.
// - Latency, rd_lo with ack at cycle k after REQ entry: mux_oe_n=0 at cycle k+2.
// - mux_oe_n is never low while ior_s is high for more than 1 cycle. Never low in IDLE or REQ.
// - IOR released during REQ: stay in REQ until ack, load snapshot, then IDLE (no drive).
// - Back-to-back strobes: a new strobe is taken only after ior_s has been seen high for 1 cycle in IDLE.
// - Async reset mid-cycle: all outputs go to reset values immediately; iochrdy releases.
// CONFIGURATION
// - SM2201_RD_TIMEOUT_EN defined:
//   - counter runs in REQ. At TIMEOUT_CYCLES: snapshot<=ABORT_WORD, camac_req=0, rd_timeout<=1, -> DRV_LO.
//   - rd_timeout cleared by the next successful ack.
// - Undefined: no counter; REQ waits forever; rd_timeout tied 0.
// STRUCTURE
// - Package sm2201_pkg: FSM state enum (IDLE, REQ, DRV_LO, DRV_HI), ABORT_WORD default, byte-lane constants.
// - One sub-module: sm2201_sync_bit (SYNC_STAGES flop synchronizer, rst_n reset to 1) for ior_n.
// TESTING
// - Low-byte read, ack 3 cycles after camac_req with 16'hA55A:
//   -> iochrdy low until ack, mux_a=8'h5A, mux_sel=0, mux_oe_n=0 until IOR rises.
// - Follow with high-byte read: no camac_req; mux_sel=1, mux_b=8'hA5, mux_oe_n low only during strobe.
// - New low read with camac_data=16'h1234, then high read -> 8'h34 then 8'h12.
//   Check mux_sel settles >=1 cycle before mux_oe_n=0.
// - IOR released in REQ, ack later with 16'hBEEF:
//   -> mux_oe_n stays 1, snapshot=16'hBEEF, return to IDLE.
// - With SM2201_RD_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack:
//   -> after 8 cycles snapshot=16'hFFFF, rd_timeout=1, iochrdy=1, mux_a=8'hFF driven.
//   A later good ack clears rd_timeout.
// - rst_n pulsed low during REQ and during DRV_LO -> all outputs take reset values at once; FSM IDLE.

Source files
------------

// File: rtl/sm2201_pkg.sv
// sm2201_pkg: shared types and constants for the SM2201 ISA read path.
//   rd_state_t     read-path FSM states
//   ABORT_WORD_DEF snapshot value loaded when a CAMAC read is abandoned
//   BYTE_W, LANE_* byte-lane width and SN74LS257 select encodings
package sm2201_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DRV_LO = 2'd2,
        DRV_HI = 2'd3
    } rd_state_t;

    localparam logic [15:0] ABORT_WORD_DEF = 16'hFFFF;
    localparam int          BYTE_W         = 8;
    localparam logic        LANE_LO        = 1'b0;
    localparam logic        LANE_HI        = 1'b1;

endpackage

// File: rtl/sm2201_sync_bit.sv
// sm2201_sync_bit: STAGES-deep flop synchronizer for one async level, resets to 1.
//   clk, rst_n  clock, asynchronous active-low reset
//   d           asynchronous input
//   q           synchronized output
module sm2201_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain <= '1;
        else
            chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sm2201_rd_mux_ctrl.sv
// sm2201_rd_mux_ctrl: ISA-side read sequencer for the SM2201 ISA-CAMAC interface.
//   Owns the 16-bit read snapshot feeding the two SN74LS257 byte muxes and drives
//   their select/output-enable. A low-byte read fetches a fresh CAMAC word while
//   holding iochrdy low; a high-byte read returns the same snapshot.
//   Optional macro SM2201_RD_TIMEOUT_EN: abort a CAMAC fetch after TIMEOUT_CYCLES,
//   load ABORT_WORD and raise sticky rd_timeout (cleared by the next good ack).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ior_n                    async ISA IOR strobe, active low
//   addr_hit, addr_a0        read-port decode and byte select (stable while ior_n low)
//   camac_req/ack/data       CAMAC word fetch handshake
//   iochrdy                  ISA ready, 0 inserts wait states
//   mux_a, mux_b             snapshot low/high byte to the mux inputs
//   mux_sel, mux_oe_n        mux select (0 = a) and out_control (1 = Z)
//   rd_timeout               sticky abort flag
module sm2201_rd_mux_ctrl
    import sm2201_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ABORT_WORD     = ABORT_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ior_n,
    input  logic        addr_hit,
    input  logic        addr_a0,
    output logic        camac_req,
    input  logic        camac_ack,
    input  logic [15:0] camac_data,
    output logic        iochrdy,
    output logic [7:0]  mux_a,
    output logic [7:0]  mux_b,
    output logic        mux_sel,
    output logic        mux_oe_n,
    output logic        rd_timeout
);

    rd_state_t   state;
    logic [15:0] snapshot;
    logic        ior_s;
    logic        armed;
    logic        rd_lo;
    logic        rd_hi;
    logic        timeout_hit;

    sm2201_sync_bit #(.STAGES(SYNC_STAGES)) u_ior_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ior_n),
        .q     (ior_s)
    );

    assign rd_lo = !ior_s && addr_hit && !addr_a0;
    assign rd_hi = !ior_s && addr_hit &&  addr_a0;

    assign mux_a = snapshot[BYTE_W-1:0];
    assign mux_b = snapshot[2*BYTE_W-1:BYTE_W];

`ifdef SM2201_RD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          timeout_q;

    // An ack arriving on the final cycle wins over the abort.
    assign timeout_hit = (state == REQ) && !camac_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign rd_timeout  = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt <= (state == REQ) ? cnt + 1'b1 : '0;
            if (state == REQ && camac_ack)
                timeout_q <= 1'b0;
            else if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rd_timeout  = 1'b0;
`endif

    // armed records that ior_s was high during the previous IDLE cycle, so a
    // strobe still held low after a drive phase is not taken twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            camac_req <= 1'b0;
            iochrdy   <= 1'b1;
            mux_oe_n  <= 1'b1;
            mux_sel   <= LANE_LO;
            snapshot  <= '0;
        end else begin
            armed <= (state == IDLE) && ior_s;
            case (state)
                IDLE: begin
                    if (armed && rd_lo) begin
                        camac_req <= 1'b1;
                        iochrdy   <= 1'b0;
                        state     <= REQ;
                    end else if (armed && rd_hi) begin
                        mux_sel <= LANE_HI;
                        state   <= DRV_HI;
                    end
                end
                REQ: begin
                    if (camac_ack || timeout_hit) begin
                        snapshot  <= camac_ack ? camac_data : ABORT_WORD;
                        camac_req <= 1'b0;
                        iochrdy   <= 1'b1;
                        mux_sel   <= LANE_LO;
                        // Strobe already gone: keep the word but do not drive the bus.
                        state     <= ior_s ? IDLE : DRV_LO;
                    end
                end
                DRV_LO, DRV_HI: begin
                    if (ior_s) begin
                        mux_oe_n <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        mux_oe_n <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm2201_rd_mux_ctrl.sv
module tb_sm2201_rd_mux_ctrl;

    localparam int SYNC = 2;
    localparam int TO   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ior_n = 1'b1;
    logic        addr_hit = 1'b0;
    logic        addr_a0 = 1'b0;
    logic        camac_ack = 1'b0;
    logic [15:0] camac_data = '0;
    logic        camac_req, iochrdy, mux_sel, mux_oe_n, rd_timeout;
    logic [7:0]  mux_a, mux_b;

    logic [15:0] snap = '0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sm2201_rd_mux_ctrl #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ior_n      (ior_n),
        .addr_hit   (addr_hit),
        .addr_a0    (addr_a0),
        .camac_req  (camac_req),
        .camac_ack  (camac_ack),
        .camac_data (camac_data),
        .iochrdy    (iochrdy),
        .mux_a      (mux_a),
        .mux_b      (mux_b),
        .mux_sel    (mux_sel),
        .mux_oe_n   (mux_oe_n),
        .rd_timeout (rd_timeout)
    );

    task automatic release_strobe(input string tag);
        int n;
        ior_n = 1'b1;
        n = 0;
        while (mux_oe_n !== 1'b1 && n < SYNC + 4) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (mux_oe_n !== 1'b1 || n > SYNC + 1) begin
            n_err++;
            $display("FAIL %s release: mux_oe_n=%b after %0d cycles, want 1 within %0d", tag, mux_oe_n, n, SYNC + 1);
        end
        addr_hit = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int n;
        bit ok;
        n = 0;
        ok = 1;
        while (camac_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
            if (mux_oe_n !== 1'b1) ok = 0;
        end
        n_cmp++;
        if (camac_req !== 1'b1 || iochrdy !== 1'b0 || !ok) begin
            n_err++;
            $display("FAIL %s req: camac_req=%b iochrdy=%b oe_ok=%0d, want 1/0/1", tag, camac_req, iochrdy, ok);
        end
    endtask

    task automatic rd_lo(input logic [15:0] w, input int dly, input string tag);
        int n;
        bit ok;
        logic prev_sel;
        addr_hit = 1'b1;
        addr_a0  = 1'b0;
        ior_n    = 1'b0;
        wait_req(tag);
        ok = 1;
        repeat (dly) begin
            @(negedge clk);
            if (camac_req !== 1'b1 || iochrdy !== 1'b0 || mux_oe_n !== 1'b1) ok = 0;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s wait: req/iochrdy/oe left 1/0/1 before ack, got %b/%b/%b", tag, camac_req, iochrdy, mux_oe_n);
        end
        camac_data = w;
        camac_ack  = 1'b1;
        @(negedge clk);
        camac_ack  = 1'b0;
        camac_data = 16'($urandom);
        snap = w;
        n_cmp++;
        if (camac_req !== 1'b0 || iochrdy !== 1'b1 || rd_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack: req=%b iochrdy=%b rd_timeout=%b, want 0/1/0", tag, camac_req, iochrdy, rd_timeout);
        end
        n = 0;
        prev_sel = mux_sel;
        while (mux_oe_n !== 1'b0 && n < 4) begin
            prev_sel = mux_sel;
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (mux_oe_n !== 1'b0 || n != 1 || prev_sel !== 1'b0) begin
            n_err++;
            $display("FAIL %s drive: oe=%b after %0d cycles, sel before=%b, want 0 after 1 with sel 0", tag, mux_oe_n, n, prev_sel);
        end
        n_cmp++;
        if (mux_sel !== 1'b0 || {mux_b, mux_a} !== snap) begin
            n_err++;
            $display("FAIL %s data: sel=%b word=%h, want sel 0 word %h", tag, mux_sel, {mux_b, mux_a}, snap);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        n_cmp++;
        if (mux_oe_n !== 1'b0) begin
            n_err++;
            $display("FAIL %s hold: oe=%b while strobe low, want 0", tag, mux_oe_n);
        end
        release_strobe(tag);
    endtask

    task automatic rd_hi(input string tag);
        int n;
        bit ok;
        logic prev_sel;
        addr_hit = 1'b1;
        addr_a0  = 1'b1;
        ior_n    = 1'b0;
        n = 0;
        ok = 1;
        prev_sel = mux_sel;
        while (mux_oe_n !== 1'b0 && n < 10) begin
            prev_sel = mux_sel;
            @(negedge clk);
            n++;
            if (camac_req !== 1'b0 || iochrdy !== 1'b1) ok = 0;
        end
        n_cmp++;
        if (mux_oe_n !== 1'b0 || prev_sel !== 1'b1 || !ok) begin
            n_err++;
            $display("FAIL %s hi drive: oe=%b sel before=%b no_fetch=%0d, want 0/1/1", tag, mux_oe_n, prev_sel, ok);
        end
        n_cmp++;
        if (mux_sel !== 1'b1 || mux_b !== snap[15:8] || mux_a !== snap[7:0]) begin
            n_err++;
            $display("FAIL %s hi data: sel=%b b=%h a=%h, want 1 %h %h", tag, mux_sel, mux_b, mux_a, snap[15:8], snap[7:0]);
        end
        release_strobe(tag);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (camac_req !== 1'b0 || iochrdy !== 1'b1 || mux_oe_n !== 1'b1 || mux_sel !== 1'b0 ||
            {mux_b, mux_a} !== 16'h0000 || rd_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset: req=%b rdy=%b oe=%b sel=%b word=%h to=%b, want 0 1 1 0 0000 0",
                     camac_req, iochrdy, mux_oe_n, mux_sel, {mux_b, mux_a}, rd_timeout);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_directed;
        rd_lo(16'hA55A, 3, "lo_a55a");
        rd_hi("hi_a55a");
        rd_lo(16'h1234, 1, "lo_1234");
        rd_hi("hi_1234");
    endtask

    task automatic test_stray;
        camac_data = 16'hDEAD;
        camac_ack  = 1'b1;
        @(negedge clk);
        camac_ack  = 1'b0;
        addr_hit = 1'b0;
        ior_n = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (camac_req !== 1'b0 || mux_oe_n !== 1'b1 || iochrdy !== 1'b1) begin
            n_err++;
            $display("FAIL stray: req=%b oe=%b rdy=%b for foreign strobe, want 0 1 1", camac_req, mux_oe_n, iochrdy);
        end
        ior_n = 1'b1;
        repeat (4) @(negedge clk);
        rd_hi("stray_hi");
    endtask

    task automatic test_release_in_req;
        bit ok;
        addr_hit = 1'b1;
        addr_a0  = 1'b0;
        ior_n    = 1'b0;
        wait_req("rel_req");
        ior_n = 1'b1;
        repeat (5) @(negedge clk);
        camac_data = 16'hBEEF;
        camac_ack  = 1'b1;
        @(negedge clk);
        camac_ack = 1'b0;
        snap = 16'hBEEF;
        ok = 1;
        repeat (6) begin
            if (mux_oe_n !== 1'b1) ok = 0;
            @(negedge clk);
        end
        n_cmp++;
        if (!ok || {mux_b, mux_a} !== 16'hBEEF || iochrdy !== 1'b1 || camac_req !== 1'b0) begin
            n_err++;
            $display("FAIL rel_req: oe_quiet=%0d word=%h rdy=%b req=%b, want 1 beef 1 0", ok, {mux_b, mux_a}, iochrdy, camac_req);
        end
        addr_hit = 1'b0;
        rd_hi("rel_hi");
    endtask

    task automatic test_timeout;
`ifdef SM2201_RD_TIMEOUT_EN
        int n;
        addr_hit = 1'b1;
        addr_a0  = 1'b0;
        ior_n    = 1'b0;
        wait_req("to");
        n = 0;
        while (iochrdy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != TO || rd_timeout !== 1'b1 || camac_req !== 1'b0) begin
            n_err++;
            $display("FAIL to abort: after %0d cycles rd_timeout=%b req=%b, want %0d cycles 1 0", n, rd_timeout, camac_req, TO);
        end
        snap = 16'hFFFF;
        @(negedge clk);
        n_cmp++;
        if (mux_oe_n !== 1'b0 || mux_a !== 8'hFF || mux_b !== 8'hFF) begin
            n_err++;
            $display("FAIL to drive: oe=%b a=%h b=%h, want 0 ff ff", mux_oe_n, mux_a, mux_b);
        end
        release_strobe("to");
        n_cmp++;
        if (rd_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL to sticky: rd_timeout=%b, want 1", rd_timeout);
        end
        rd_lo(16'($urandom), 2, "to_clear");
`else
        bit ok;
        addr_hit = 1'b1;
        addr_a0  = 1'b0;
        ior_n    = 1'b0;
        wait_req("no_to");
        ok = 1;
        repeat (5 * TO) begin
            @(negedge clk);
            if (camac_req !== 1'b1 || iochrdy !== 1'b0 || rd_timeout !== 1'b0 || mux_oe_n !== 1'b1) ok = 0;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL no_to: req=%b rdy=%b to=%b oe=%b, want REQ held 1 0 0 1", camac_req, iochrdy, rd_timeout, mux_oe_n);
        end
        camac_data = 16'h5AA5;
        camac_ack  = 1'b1;
        @(negedge clk);
        camac_ack = 1'b0;
        snap = 16'h5AA5;
        @(negedge clk);
        n_cmp++;
        if (mux_oe_n !== 1'b0 || {mux_b, mux_a} !== 16'h5AA5 || iochrdy !== 1'b1) begin
            n_err++;
            $display("FAIL no_to late ack: oe=%b word=%h rdy=%b, want 0 5aa5 1", mux_oe_n, {mux_b, mux_a}, iochrdy);
        end
        release_strobe("no_to");
`endif
    endtask

    task automatic test_reset_mid;
        addr_hit = 1'b1;
        addr_a0  = 1'b0;
        ior_n    = 1'b0;
        wait_req("rst_req");
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (camac_req !== 1'b0 || iochrdy !== 1'b1 || mux_oe_n !== 1'b1 || mux_sel !== 1'b0) begin
            n_err++;
            $display("FAIL rst_req: req=%b rdy=%b oe=%b sel=%b, want 0 1 1 0", camac_req, iochrdy, mux_oe_n, mux_sel);
        end
        ior_n = 1'b1;
        addr_hit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        snap = 16'h0000;
        repeat (3) @(negedge clk);
        rd_hi("rst_req_hi");
        addr_hit = 1'b1;
        addr_a0  = 1'b0;
        ior_n    = 1'b0;
        wait_req("rst_drv");
        camac_data = 16'hC3C3;
        camac_ack  = 1'b1;
        @(negedge clk);
        camac_ack = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mux_oe_n !== 1'b1 || {mux_b, mux_a} !== 16'h0000 || iochrdy !== 1'b1 || camac_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_drv: oe=%b word=%h rdy=%b req=%b, want 1 0000 1 0", mux_oe_n, {mux_b, mux_a}, iochrdy, camac_req);
        end
        ior_n = 1'b1;
        addr_hit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        snap = 16'h0000;
        repeat (3) @(negedge clk);
        rd_hi("rst_drv_hi");
    endtask

    task automatic test_random;
        for (int i = 0; i < 14; i++) begin
            rd_lo(16'($urandom), $urandom_range(0, 12), "rand_lo");
            if ($urandom_range(0, 1) == 1) rd_hi("rand_hi");
            if ($urandom_range(0, 3) == 0) rd_hi("rand_hi2");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stray;
        test_release_in_req;
        test_timeout;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
